ext_pipe: RTL and testbench

EXT_PIPE -- requirements
Module: ext_pipe

---
 rtl/ext_pkg.sv | 15 +
 rtl/ext_core.sv | 50 +++++
 rtl/ext_pipe.sv | 76 +++++++
 tb/tb_ext_pipe.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared operation encodings for the extend/select datapath and any other decode logic.
package ext_pkg;

    typedef enum logic [2:0] {
        MODE_ZERO = 3'd0,
        MODE_SIGN = 3'd1,
        MODE_HIGH = 3'd2,
        MODE_LB_S = 3'd3,
        MODE_LB_U = 3'd4,
        MODE_LH_S = 3'd5,
        MODE_LH_U = 3'd6,
        MODE_PASS = 3'd7
    } mode_e;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extend / byte-halfword load select; zero latency, no flow control.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  mode_e                          mode,
    input  logic [OUT_W-1:0]               data,
    input  logic [$clog2(OUT_W/8)-1:0]     off,
    output logic [OUT_W-1:0]               result,
    output logic                           misalign
);

    localparam int OFF_W = $clog2(OUT_W/8);

    logic [IN_W-1:0]  imm;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [OFF_W-1:0] off_h;

    // Halfword loads ignore the low offset bit; the odd case is flagged, not trapped.
    assign off_h  = off & ~OFF_W'(1);
    assign imm    = data[IN_W-1:0];
    assign byte_v = data[{off, 3'b000} +: 8];
    assign half_v = data[{off_h, 3'b000} +: 16];

    always_comb begin
        result   = '0;
        misalign = 1'b0;
        case (mode)
            MODE_ZERO: result = OUT_W'(imm);
            MODE_SIGN: result = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            MODE_HIGH: result = {imm, {(OUT_W-IN_W){1'b0}}};
            MODE_LB_S: result = {{(OUT_W-8){byte_v[7]}}, byte_v};
            MODE_LB_U: result = OUT_W'(byte_v);
            MODE_LH_S: begin
                result   = {{(OUT_W-16){half_v[15]}}, half_v};
                misalign = off[0];
            end
            MODE_LH_U: begin
                result   = OUT_W'(half_v);
                misalign = off[0];
            end
            MODE_PASS: result = data;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Registered extend stage: latency 1 into a free output register, one transfer per cycle.
// Back-pressure absorbed by a 1-entry skid; in_ready is registered and low only while the skid holds data.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_mode,
    input  logic [OUT_W-1:0]           in_data,
    input  logic [$clog2(OUT_W/8)-1:0] in_off,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_misalign
);

    logic [OUT_W-1:0] core_res;
    logic             core_mis;
    logic [OUT_W-1:0] skid_dat;
    logic             skid_mis;
    logic             skid_vld;
    logic             skid_vld_nxt;
    logic             acc;
    logic             load_out;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode     (mode_e'(in_mode)),
        .data     (in_data),
        .off      (in_off),
        .result   (core_res),
        .misalign (core_mis)
    );

    assign acc      = in_valid && in_ready;
    assign load_out = !out_valid || out_ready;
    // The skid only ever fills behind a held output, so it drains exactly when the output does.
    assign skid_vld_nxt = skid_vld ? !load_out : (acc && !load_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_misalign <= 1'b0;
            skid_vld     <= 1'b0;
            skid_dat     <= '0;
            skid_mis     <= 1'b0;
            in_ready     <= 1'b0;
        end else begin
            if (load_out) begin
                out_valid <= skid_vld || acc;
                if (skid_vld) begin
                    out_data     <= skid_dat;
                    out_misalign <= skid_mis;
                end else if (acc) begin
                    out_data     <= core_res;
                    out_misalign <= core_mis;
                end
            end
            if (acc && !load_out) begin
                skid_dat <= core_res;
                skid_mis <= core_mis;
            end
            skid_vld <= skid_vld_nxt;
            in_ready <= !skid_vld_nxt;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: extend modes, back-pressure through the skid, async reset mid-flight.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_mode = 3'd0;
    logic [31:0] in_data = 32'd0;
    logic [1:0]  in_off = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .in_off       (in_off),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_misalign (out_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic [31:0] d, input logic [1:0] o);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_off   = o;
    endtask

    localparam int NV = 12;
    logic [2:0]  v_mode [NV] = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd6, 3'd5,
                                 3'd4, 3'd3, 3'd5, 3'd6, 3'd7, 3'd1};
    logic [31:0] v_data [NV] = '{32'h0000_8001, 32'h0000_1234, 32'hABCD_FFFF, 32'h80FF_7F01,
                                 32'h80FF_7F01, 32'h0000_8000, 32'h80FF_7F01, 32'h80FF_7F01,
                                 32'h80FF_7F01, 32'h80FF_7F01, 32'hDEAD_BEEF, 32'h5555_7FFF};
    logic [1:0]  v_off  [NV] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1,
                                 2'd1, 2'd0, 2'd0, 2'd3, 2'd2, 2'd0};
    logic [31:0] v_exp  [NV] = '{32'hFFFF_8001, 32'h1234_0000, 32'h0000_FFFF, 32'hFFFF_FF80,
                                 32'h0000_80FF, 32'hFFFF_8000, 32'h0000_007F, 32'h0000_0001,
                                 32'h0000_7F01, 32'h0000_80FF, 32'hDEAD_BEEF, 32'h0000_7FFF};
    logic        v_mis  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_misalign", 32'(out_misalign), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back vectors: each result one cycle after acceptance
        for (int i = 0; i < NV; i++) begin
            drive(v_mode[i], v_data[i], v_off[i]);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), out_data, v_exp[i]);
            chk($sformatf("vec%0d_mis", i), 32'(out_misalign), 32'(v_mis[i]));
            chk($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Back-pressure: A to output, B to skid, C refused until the skid drains
        out_ready = 1'b0;
        drive(3'd0, 32'h0000_0011, 2'd0);
        tick();
        chk("bp1_data", out_data, 32'h0000_0011);
        chk("bp1_rdy", 32'(in_ready), 32'd1);
        drive(3'd0, 32'h0000_0022, 2'd0);
        tick();
        chk("bp2_data", out_data, 32'h0000_0011);
        chk("bp2_rdy", 32'(in_ready), 32'd0);
        drive(3'd0, 32'h0000_0033, 2'd0);
        tick();
        chk("bp3_valid", 32'(out_valid), 32'd1);
        chk("bp3_data", out_data, 32'h0000_0011);
        chk("bp3_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp4_data", out_data, 32'h0000_0022);
        chk("bp4_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("bp5_data", out_data, 32'h0000_0033);
        drive(3'd1, 32'h0000_8044, 2'd0);
        tick();
        chk("bp6_data", out_data, 32'hFFFF_8044);
        chk("bp6_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp7_valid", 32'(out_valid), 32'd0);

        // Async reset with output held and skid full
        out_ready = 1'b0;
        drive(3'd7, 32'h1111_1111, 2'd0);
        tick();
        drive(3'd7, 32'h2222_2222, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_rdy", 32'(in_ready), 32'd0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("arel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("no_stale%0d", i), 32'(out_valid), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
